// File: rtl/datapath_pkg.sv
// Shared types and constants for the shared-bus CPU datapath: bus-source and ALU-op
// encodings, plus the decoders that turn one-hot strobe vectors into them.
package datapath_pkg;

  localparam int WORD_W  = 32;
  localparam int CSE_W   = 19;
  localparam int NUM_GPR = 16;
  localparam int NUM_SRC = 26;
  localparam int NUM_OPS = 14;

  // Encoding order is the select priority order (index i of the select vector maps to value i+1).
  typedef enum logic [3:0] {
    OP_NONE, OP_INCPC, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
    OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT
  } alu_op_e;

  typedef enum logic [4:0] {
    SRC_R0, SRC_R1, SRC_R2, SRC_R3, SRC_R4, SRC_R5, SRC_R6, SRC_R7,
    SRC_R8, SRC_R9, SRC_R10, SRC_R11, SRC_R12, SRC_R13, SRC_R14, SRC_R15,
    SRC_HI, SRC_LO, SRC_ZHI, SRC_ZLO, SRC_PC, SRC_MDR, SRC_MAR, SRC_INPORT,
    SRC_CSE, SRC_IR, SRC_NONE
  } bus_src_e;

  // Lowest set bit wins.
  function automatic bus_src_e pick_src(input logic [NUM_SRC-1:0] sel);
    pick_src = SRC_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (sel[i]) pick_src = bus_src_e'(5'(i));
  endfunction

  function automatic alu_op_e pick_op(input logic [NUM_OPS-1:0] sel);
    pick_op = OP_NONE;
    for (int i = NUM_OPS - 1; i >= 0; i--)
      if (sel[i]) pick_op = alu_op_e'(4'(i + 1));
  endfunction

  function automatic logic [WORD_W-1:0] sext_cse(input logic [CSE_W-1:0] imm);
    return {{(WORD_W - CSE_W){imm[CSE_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control-strobe bundle between the control unit (master) and the datapath (slave).
// op_sel bit order: IncPC, ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT.
interface datapath_if;
  logic [datapath_pkg::NUM_GPR-1:0] r_in, r_out;
  logic hi_in, lo_in, zhigh_in, zlow_in, pc_in, mdr_in, mar_in, inport_in, cse_in, ir_in, y_in;
  logic hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out, mar_out, inport_out, cse_out, ir_out;
  logic [datapath_pkg::WORD_W-1:0]  mdatain;
  logic                             md_mux_read;
  logic [datapath_pkg::NUM_OPS-1:0] op_sel;
  logic [datapath_pkg::WORD_W-1:0]  bus;

  modport master (
    output r_in, r_out, hi_in, lo_in, zhigh_in, zlow_in, pc_in, mdr_in, mar_in, inport_in,
           cse_in, ir_in, y_in, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out,
           mar_out, inport_out, cse_out, ir_out, mdatain, md_mux_read, op_sel,
    input  bus
  );

  modport slave (
    input  r_in, r_out, hi_in, lo_in, zhigh_in, zlow_in, pc_in, mdr_in, mar_in, inport_in,
           cse_in, ir_in, y_in, hi_out, lo_out, zhigh_out, zlow_out, pc_out, mdr_out,
           mar_out, inport_out, cse_out, ir_out, mdatain, md_mux_read, op_sel,
    output bus
  );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU: A = Y, B = bus, 64-bit {hi, lo} result.
// MUL/DIV hardware exists only when DATAPATH_MULDIV_EN is defined; otherwise they yield 0.
module alu
  import datapath_pkg::*;
(
  input  logic [WORD_W-1:0]   a,
  input  logic [WORD_W-1:0]   b,
  input  alu_op_e             op,
  output logic [2*WORD_W-1:0] res
);

  logic [4:0]          amt;
  logic [2*WORD_W-1:0] rot_r, rot_l;

  // Rotates fall out of shifting the doubled word.
  assign amt   = b[4:0];
  assign rot_r = {a, a} >> amt;
  assign rot_l = {a, a} << amt;

`ifdef DATAPATH_MULDIV_EN
  logic [2*WORD_W-1:0] prod;
  logic [WORD_W-1:0]   quot, rem;
  logic                div_ovf;

  assign prod    = $signed({{WORD_W{a[WORD_W-1]}}, a}) * $signed({{WORD_W{b[WORD_W-1]}}, b});
  assign div_ovf = (a == {1'b1, {(WORD_W-1){1'b0}}}) && (&b);

  // Divide by zero returns all-ones / dividend; MIN / -1 wraps instead of trapping.
  always_comb begin
    quot = '1;
    rem  = a;
    if (div_ovf) begin
      quot = a;
      rem  = '0;
    end else if (b != '0) begin
      quot = $signed(a) / $signed(b);
      rem  = $signed(a) % $signed(b);
    end
  end
`endif

  always_comb begin
    res = '0;
    case (op)
      OP_INCPC: res[WORD_W-1:0] = b + 32'd1;
      OP_ADD:   res[WORD_W-1:0] = a + b;
      OP_SUB:   res[WORD_W-1:0] = a - b;
      OP_AND:   res[WORD_W-1:0] = a & b;
      OP_OR:    res[WORD_W-1:0] = a | b;
      OP_SHR:   res[WORD_W-1:0] = a >> amt;
      OP_SHRA:  res[WORD_W-1:0] = $signed(a) >>> amt;
      OP_SHL:   res[WORD_W-1:0] = a << amt;
      OP_ROR:   res[WORD_W-1:0] = rot_r[WORD_W-1:0];
      OP_ROL:   res[WORD_W-1:0] = rot_l[2*WORD_W-1:WORD_W];
      OP_NEG:   res[WORD_W-1:0] = 32'd0 - b;
      OP_NOT:   res[WORD_W-1:0] = ~b;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:   res = prod;
      OP_DIV:   res = {rem, quot};
`endif
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Shared-bus register-transfer datapath: bus priority mux, register file and ALU hookup.
// Optional MUL/DIV selected by the DATAPATH_MULDIV_EN build macro (see alu).
module datapath
  import datapath_pkg::*;
(
  input  logic clear,
  input  logic clock,
  input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic HIin, LOin, Zhighin, Zlowin, PCin, MDRin, MARin, InPortin, CSEin, IRin, Yin,
  input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, MARout, InPortout, CSEout, IRout,
  input  logic [31:0] Mdatain,
  input  logic MDMuxread,
  input  logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, IncPC,
  output logic [31:0] BusMuxOut
);

  logic [NUM_GPR-1:0]  r_in_v, r_out_v;
  logic [NUM_SRC-1:0]  out_sel;
  logic [NUM_OPS-1:0]  op_sel;
  bus_src_e            src;
  logic [4:0]          src_idx;
  alu_op_e             op;
  logic [WORD_W-1:0]   bus;
  logic [2*WORD_W-1:0] alu_res;

  logic [NUM_GPR-1:0][WORD_W-1:0] r_q, r_d;
  logic [WORD_W-1:0] hi_q, hi_d, lo_q, lo_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [WORD_W-1:0] pc_q, pc_d, mdr_q, mdr_d, mar_q, mar_d, inport_q, inport_d;
  logic [WORD_W-1:0] cse_q, cse_d, ir_q, ir_d, y_q, y_d;

  assign r_in_v  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out_v = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign out_sel = {IRout, CSEout, InPortout, MARout, MDRout, PCout,
                    Zlowout, Zhighout, LOout, HIout, r_out_v};
  assign op_sel  = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV, MUL, SUB, ADD, IncPC};

  assign src     = pick_src(out_sel);
  assign src_idx = src;
  assign op      = pick_op(op_sel);

  always_comb begin
    bus = '0;
    case (src)
      SRC_HI:     bus = hi_q;
      SRC_LO:     bus = lo_q;
      SRC_ZHI:    bus = zhi_q;
      SRC_ZLO:    bus = zlo_q;
      SRC_PC:     bus = pc_q;
      SRC_MDR:    bus = mdr_q;
      SRC_MAR:    bus = mar_q;
      SRC_INPORT: bus = inport_q;
      SRC_CSE:    bus = cse_q;
      SRC_IR:     bus = ir_q;
      SRC_NONE:   bus = '0;
      default:    bus = r_q[src_idx[3:0]];
    endcase
  end

  assign BusMuxOut = bus;

  alu u_alu (
    .a  (y_q),
    .b  (bus),
    .op (op),
    .res(alu_res)
  );

  always_comb begin
    r_d = r_q;
    for (int i = 0; i < NUM_GPR; i++)
      if (r_in_v[i]) r_d[i] = bus;
    hi_d     = HIin     ? bus : hi_q;
    lo_d     = LOin     ? bus : lo_q;
    pc_d     = PCin     ? bus : pc_q;
    mar_d    = MARin    ? bus : mar_q;
    inport_d = InPortin ? bus : inport_q;
    ir_d     = IRin     ? bus : ir_q;
    y_d      = Yin      ? bus : y_q;
    mdr_d    = MDRin    ? (MDMuxread ? Mdatain : bus) : mdr_q;
    zhi_d    = Zhighin  ? alu_res[2*WORD_W-1:WORD_W] : zhi_q;
    zlo_d    = Zlowin   ? alu_res[WORD_W-1:0] : zlo_q;
    // CSE takes the immediate field of the IR as it stands before this edge.
    cse_d    = CSEin    ? sext_cse(ir_q[CSE_W-1:0]) : cse_q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      pc_q     <= '0;
      mdr_q    <= '0;
      mar_q    <= '0;
      inport_q <= '0;
      cse_q    <= '0;
      ir_q     <= '0;
      y_q      <= '0;
    end else begin
      r_q      <= r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zhi_q    <= zhi_d;
      zlo_q    <= zlo_d;
      pc_q     <= pc_d;
      mdr_q    <= mdr_d;
      mar_q    <= mar_d;
      inport_q <= inport_d;
      cse_q    <= cse_d;
      ir_q     <= ir_d;
      y_q      <= y_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Scoreboarded bench for datapath: directed fetch/ALU/priority/reset cases, then random transfers
// checked against a transfer-level model of the register set.
module tb_datapath;

  localparam int S_HI = 16, S_LO = 17, S_ZHI = 18, S_ZLO = 19, S_PC = 20, S_MDR = 21;
  localparam int S_MAR = 22, S_IN = 23, S_CSE = 24, S_IR = 25, S_Y = 26, NSRC = 26;
  localparam int O_INC = 0, O_ADD = 1, O_SUB = 2, O_MUL = 3, O_DIV = 4, O_AND = 5, O_OR = 6;
  localparam int O_SHR = 7, O_SHRA = 8, O_SHL = 9, O_ROR = 10, O_ROL = 11, O_NEG = 12, O_NOT = 13;

  logic clock, clear, chk;
  datapath_if ctl ();

  logic [31:0] m [27];
  logic [31:0] exp_q [$];
  int n_cmp, n_bad;

  datapath dut (
    .clear(clear), .clock(clock),
    .R0in(ctl.r_in[0]), .R1in(ctl.r_in[1]), .R2in(ctl.r_in[2]), .R3in(ctl.r_in[3]),
    .R4in(ctl.r_in[4]), .R5in(ctl.r_in[5]), .R6in(ctl.r_in[6]), .R7in(ctl.r_in[7]),
    .R8in(ctl.r_in[8]), .R9in(ctl.r_in[9]), .R10in(ctl.r_in[10]), .R11in(ctl.r_in[11]),
    .R12in(ctl.r_in[12]), .R13in(ctl.r_in[13]), .R14in(ctl.r_in[14]), .R15in(ctl.r_in[15]),
    .HIin(ctl.hi_in), .LOin(ctl.lo_in), .Zhighin(ctl.zhigh_in), .Zlowin(ctl.zlow_in),
    .PCin(ctl.pc_in), .MDRin(ctl.mdr_in), .MARin(ctl.mar_in), .InPortin(ctl.inport_in),
    .CSEin(ctl.cse_in), .IRin(ctl.ir_in), .Yin(ctl.y_in),
    .R0out(ctl.r_out[0]), .R1out(ctl.r_out[1]), .R2out(ctl.r_out[2]), .R3out(ctl.r_out[3]),
    .R4out(ctl.r_out[4]), .R5out(ctl.r_out[5]), .R6out(ctl.r_out[6]), .R7out(ctl.r_out[7]),
    .R8out(ctl.r_out[8]), .R9out(ctl.r_out[9]), .R10out(ctl.r_out[10]), .R11out(ctl.r_out[11]),
    .R12out(ctl.r_out[12]), .R13out(ctl.r_out[13]), .R14out(ctl.r_out[14]), .R15out(ctl.r_out[15]),
    .HIout(ctl.hi_out), .LOout(ctl.lo_out), .Zhighout(ctl.zhigh_out), .Zlowout(ctl.zlow_out),
    .PCout(ctl.pc_out), .MDRout(ctl.mdr_out), .MARout(ctl.mar_out), .InPortout(ctl.inport_out),
    .CSEout(ctl.cse_out), .IRout(ctl.ir_out),
    .Mdatain(ctl.mdatain), .MDMuxread(ctl.md_mux_read),
    .ADD(ctl.op_sel[O_ADD]), .SUB(ctl.op_sel[O_SUB]), .MUL(ctl.op_sel[O_MUL]),
    .DIV(ctl.op_sel[O_DIV]), .AND(ctl.op_sel[O_AND]), .OR(ctl.op_sel[O_OR]),
    .SHR(ctl.op_sel[O_SHR]), .SHRA(ctl.op_sel[O_SHRA]), .SHL(ctl.op_sel[O_SHL]),
    .ROR(ctl.op_sel[O_ROR]), .ROL(ctl.op_sel[O_ROL]), .NEG(ctl.op_sel[O_NEG]),
    .NOT(ctl.op_sel[O_NOT]), .IncPC(ctl.op_sel[O_INC]),
    .BusMuxOut(ctl.bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [25:0] sb(input int i);
    logic [25:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [26:0] db(input int i);
    logic [26:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [13:0] ob(input int i);
    logic [13:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Arithmetic reference for the ALU: returns {hi, lo}.
  function automatic logic [63:0] ref_alu(input int opi, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] ext;
    logic [31:0] lo;
    n  = int'(b[4:0]);
    lo = '0;
    case (opi)
      O_INC:  lo = b + 32'd1;
      O_ADD:  lo = a + b;
      O_SUB:  lo = a - b;
      O_AND:  lo = a & b;
      O_OR:   lo = a | b;
      O_SHR:  lo = a >> n;
      O_SHRA: begin ext = {{32{a[31]}}, a}; ext = ext >> n; lo = ext[31:0]; end
      O_SHL:  lo = a << n;
      O_ROR:  lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      O_ROL:  lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      O_NEG:  lo = 32'd0 - b;
      O_NOT:  lo = ~b;
`ifdef DATAPATH_MULDIV_EN
      O_MUL:  return longint'($signed(a)) * longint'($signed(b));
      O_DIV: begin
        int sa, sd, q, r;
        sa = a;
        sd = b;
        if (sd == 0) return {a, 32'hFFFF_FFFF};
        if (sa == 32'h8000_0000 && sd == -1) return {32'h0, 32'h8000_0000};
        q = sa / sd;
        r = sa % sd;
        return {r, q};
      end
`endif
      default: lo = '0;
    endcase
    return {32'h0, lo};
  endfunction

  // One bus cycle: drive strobes at the falling edge, predict the bus and the next register state.
  task automatic xfer(input logic [25:0] src, input logic [26:0] dst = '0, input logic [13:0] op = '0,
                      input logic mdm = 1'b0, input logic [31:0] mdat = '0, input logic clr = 1'b0,
                      input bit use_exp = 1'b0, input logic [31:0] exp_v = '0);
    logic [31:0] bus_e, cse_new;
    logic [63:0] res;
    int opi;
    @(negedge clock);
    if (clr) foreach (m[i]) m[i] = '0;
    bus_e = '0;
    for (int i = NSRC - 1; i >= 0; i--) if (src[i]) bus_e = m[i];
    opi = -1;
    for (int k = 13; k >= 0; k--) if (op[k]) opi = k;
    res     = ref_alu(opi, m[S_Y], bus_e);
    cse_new = {{13{m[S_IR][18]}}, m[S_IR][18:0]};
    exp_q.push_back(use_exp ? exp_v : bus_e);
    if (!clr) begin
      for (int j = 0; j < 27; j++) begin
        if (dst[j]) begin
          case (j)
            S_ZHI:   m[j] = res[63:32];
            S_ZLO:   m[j] = res[31:0];
            S_MDR:   m[j] = mdm ? mdat : bus_e;
            S_CSE:   m[j] = cse_new;
            default: m[j] = bus_e;
          endcase
        end
      end
    end
    clear = clr;
    chk   = 1'b1;
    ctl.r_out = src[15:0];   ctl.hi_out = src[S_HI];   ctl.lo_out = src[S_LO];
    ctl.zhigh_out = src[S_ZHI]; ctl.zlow_out = src[S_ZLO]; ctl.pc_out = src[S_PC];
    ctl.mdr_out = src[S_MDR]; ctl.mar_out = src[S_MAR]; ctl.inport_out = src[S_IN];
    ctl.cse_out = src[S_CSE]; ctl.ir_out = src[S_IR];
    ctl.r_in = dst[15:0];    ctl.hi_in = dst[S_HI];    ctl.lo_in = dst[S_LO];
    ctl.zhigh_in = dst[S_ZHI]; ctl.zlow_in = dst[S_ZLO]; ctl.pc_in = dst[S_PC];
    ctl.mdr_in = dst[S_MDR]; ctl.mar_in = dst[S_MAR]; ctl.inport_in = dst[S_IN];
    ctl.cse_in = dst[S_CSE]; ctl.ir_in = dst[S_IR];   ctl.y_in = dst[S_Y];
    ctl.op_sel = op; ctl.md_mux_read = mdm; ctl.mdatain = mdat;
  endtask

  task automatic rd(input int s, input logic [31:0] e);
    xfer(sb(s), '0, '0, 1'b0, '0, 1'b0, 1'b1, e);
  endtask

  task automatic load(input int r, input logic [31:0] v);
    xfer('0, db(S_MDR), '0, 1'b1, v);
    xfer(sb(S_MDR), db(r));
  endtask

  task automatic alu2(input int ra, input int rb, input int o);
    xfer(sb(ra), db(S_Y));
    xfer(sb(rb), db(S_ZLO) | db(S_ZHI), ob(o));
  endtask

  // Monitor: compare the bus against the scoreboard just before each rising edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      #4;
      if (chk) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bus_sb_empty: got %08h with nothing expected", ctl.bus);
        end else begin
          e = exp_q.pop_front();
          if (ctl.bus !== e) begin
            n_bad++;
            $display("FAIL bus_cmp #%0d t=%0t: got %08h, need %08h", n_cmp, $time, ctl.bus, e);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_bad = 0; chk = 1'b0; clear = 1'b1;
    foreach (m[i]) m[i] = '0;
    ctl.r_in = '0; ctl.r_out = '0; ctl.op_sel = '0; ctl.mdatain = '0; ctl.md_mux_read = 1'b0;
    {ctl.hi_in, ctl.lo_in, ctl.zhigh_in, ctl.zlow_in, ctl.pc_in, ctl.mdr_in, ctl.mar_in,
     ctl.inport_in, ctl.cse_in, ctl.ir_in, ctl.y_in} = '0;
    {ctl.hi_out, ctl.lo_out, ctl.zhigh_out, ctl.zlow_out, ctl.pc_out, ctl.mdr_out, ctl.mar_out,
     ctl.inport_out, ctl.cse_out, ctl.ir_out} = '0;

    // Every source reads 0 under reset.
    for (int i = 0; i < NSRC; i++) xfer(sb(i), '0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0);

    // Fetch.
    xfer(sb(S_PC), db(S_MAR) | db(S_ZLO), ob(O_INC));
    xfer(sb(S_ZLO), db(S_PC) | db(S_MDR), '0, 1'b1, 32'h2891_8000);
    xfer(sb(S_MDR), db(S_IR));
    rd(S_MAR, 32'h0); rd(S_PC, 32'h1); rd(S_IR, 32'h2891_8000);
    xfer('0, db(S_CSE)); rd(S_CSE, 32'h0001_8000);
    load(S_IR, 32'h0004_0000); xfer('0, db(S_CSE)); rd(S_CSE, 32'hFFFC_0000);

    // OR into R1.
    load(2, 32'h12); load(3, 32'h14);
    xfer(sb(2), db(S_Y)); xfer(sb(3), db(S_ZLO), ob(O_OR)); xfer(sb(S_ZLO), db(1));
    rd(1, 32'h16);

    // ADD wrap, ROR by one.
    load(4, 32'hFFFF_FFFF); load(5, 32'h1);
    alu2(4, 5, O_ADD); rd(S_ZLO, 32'h0); rd(S_ZHI, 32'h0);
    load(4, 32'h1);
    alu2(4, 5, O_ROR); rd(S_ZLO, 32'h8000_0000);

    // MUL and DIV by zero.
    load(6, 32'hFFFF_FFFE); load(7, 32'h3); alu2(6, 7, O_MUL);
`ifdef DATAPATH_MULDIV_EN
    rd(S_ZHI, 32'hFFFF_FFFF); rd(S_ZLO, 32'hFFFF_FFFA);
`else
    rd(S_ZHI, 32'h0); rd(S_ZLO, 32'h0);
`endif
    load(8, 32'h7); load(9, 32'h0); alu2(8, 9, O_DIV);
`ifdef DATAPATH_MULDIV_EN
    rd(S_ZLO, 32'hFFFF_FFFF); rd(S_ZHI, 32'h7);
`else
    rd(S_ZLO, 32'h0); rd(S_ZHI, 32'h0);
`endif

    // Bus priority, idle bus, self-reload.
    xfer(sb(1) | sb(S_PC), '0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h16);
    xfer('0, '0, '0, 1'b0, '0, 1'b0, 1'b1, 32'h0);
    xfer(sb(1), db(1), '0, 1'b0, '0, 1'b0, 1'b1, 32'h16);
    rd(1, 32'h16);

    // Clear between the Y step and the Z step.
    xfer(sb(2), db(S_Y));
    xfer(sb(1), '0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0);
    rd(1, 32'h0); rd(S_ZLO, 32'h0);
    load(5, 32'h5);
    xfer(sb(5), db(S_ZLO), ob(O_ADD)); rd(S_ZLO, 32'h5);

    // Random transfers.
    for (int c = 0; c < 400; c++) begin
      logic [25:0] s;
      logic [26:0] d;
      logic [13:0] o;
      int k;
      s = '0;
      k = $urandom_range(0, 9);
      if (k != 0) s[$urandom_range(0, 25)] = 1'b1;
      if (k == 1) s[$urandom_range(0, 25)] = 1'b1;
      d = '0;
      for (int j = 0; j < 27; j++) if ($urandom_range(0, 6) == 0) d[j] = 1'b1;
      o = '0;
      k = $urandom_range(0, 5);
      if (k != 0) o[$urandom_range(0, 13)] = 1'b1;
      if (k == 1) o[$urandom_range(0, 13)] = 1'b1;
      xfer(s, d, o, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 49) == 0));
    end

    @(negedge clock);
    chk = 1'b0; clear = 1'b0;
    ctl.r_in = '0; ctl.r_out = '0; ctl.op_sel = '0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
